// File: rtl/pc_unit_gen2.sv
// Fetch-stage program counter: sequential increment, branch/jump redirect,
// exception entry / ERET return, and a one-entry buffer for redirects seen during a stall.
module pc_unit_gen2 #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int                INC       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              pc_valid,
  output logic              pending,
  output logic              adel
);

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_pend;
  logic [ADDR_W-1:0] r_ptgt;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_valid_nxt;
  logic              w_pend_nxt;
  logic [ADDR_W-1:0] w_ptgt_nxt;
  logic [ADDR_W-1:0] w_pc_inc;

  // State register: pc, BOOT/RUN flag and the EMPTY/FULL redirect buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
      r_ptgt  <= {ADDR_W{1'b0}};
    end else begin
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_pend  <= w_pend_nxt;
      r_ptgt  <= w_ptgt_nxt;
    end
  end

  // Next-state selection in strict priority: exception, ERET, boot, stall, redirect, buffered, increment
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_pend_nxt  = r_pend;
    w_ptgt_nxt  = r_ptgt;
    if (exc_req) begin
      w_pc_nxt    = EXC_VEC;
      w_pend_nxt  = 1'b0;
      w_valid_nxt = 1'b1;
    end else if (eret_req) begin
      w_pc_nxt    = epc_in;
      w_pend_nxt  = 1'b0;
      w_valid_nxt = 1'b1;
    end else if (!r_valid || stall) begin
      // pc holds; a redirect seen now is parked, newest one wins
      w_valid_nxt = 1'b1;
      if (redirect_valid) begin
        w_pend_nxt = 1'b1;
        w_ptgt_nxt = redirect_target;
      end else begin
        w_pend_nxt = r_pend;
        w_ptgt_nxt = r_ptgt;
      end
    end else if (redirect_valid) begin
      w_pc_nxt   = redirect_target;
      w_pend_nxt = 1'b0;
    end else if (r_pend) begin
      w_pc_nxt   = r_ptgt;
      w_pend_nxt = 1'b0;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  // Outputs: registered state plus the combinational increment and alignment flag
  always_comb begin
    w_pc_inc = r_pc + INC_W;
    pc       = r_pc;
    pc_valid = r_valid;
    pending  = r_pend;
    pc_plus  = w_pc_inc;
    adel     = (r_pc[1:0] != 2'b00);
  end

endmodule

// File: tb/tb_pc_unit_gen2.sv
// Bench for pc_unit_gen2: a default 32-bit instance and an 8-bit wrap-around instance,
// checked every cycle against a rule-level model plus literal pc/flag expectations.
module tb_pc_unit_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance stimulus: index 0 = default params, 1 = ADDR_W=8
  logic        rst   [2];
  logic        stl   [2];
  logic        rv    [2];
  logic        exc   [2];
  logic        eret  [2];
  logic [31:0] rtgt  [2];
  logic [31:0] epc   [2];

  logic [31:0] pc_a, pcp_a;
  logic        val_a, pend_a, adel_a;
  logic [7:0]  pc_b, pcp_b;
  logic        val_b, pend_b, adel_b;

  pc_unit_gen2 u_a (
    .clk(clk), .reset(rst[0]), .stall(stl[0]), .redirect_valid(rv[0]),
    .redirect_target(rtgt[0]), .exc_req(exc[0]), .eret_req(eret[0]), .epc_in(epc[0]),
    .pc(pc_a), .pc_plus(pcp_a), .pc_valid(val_a), .pending(pend_a), .adel(adel_a)
  );

  pc_unit_gen2 #(.ADDR_W(8), .RESET_VEC(8'hF8), .EXC_VEC(8'h80), .INC(4)) u_b (
    .clk(clk), .reset(rst[1]), .stall(stl[1]), .redirect_valid(rv[1]),
    .redirect_target(rtgt[1][7:0]), .exc_req(exc[1]), .eret_req(eret[1]), .epc_in(epc[1][7:0]),
    .pc(pc_b), .pc_plus(pcp_b), .pc_valid(val_b), .pending(pend_b), .adel(adel_b)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc [2];
  logic        m_v  [2];
  logic        m_p  [2];
  logic [31:0] m_t  [2];
  logic        m_en [2] = '{1'b0, 1'b0};

  function automatic logic [31:0] msk(input int k);
    return (k == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] rvec(input int k);
    return (k == 1) ? 32'h0000_00F8 : 32'h0000_3000;
  endfunction
  function automatic logic [31:0] xvec(input int k);
    return (k == 1) ? 32'h0000_0080 : 32'h0000_4180;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_pc[k] <= rvec(k); m_v[k] <= 1'b0; m_p[k] <= 1'b0; m_t[k] <= 32'd0; m_en[k] <= 1'b1;
      end else if (exc[k]) begin
        m_pc[k] <= xvec(k); m_p[k] <= 1'b0; m_v[k] <= 1'b1;
      end else if (eret[k]) begin
        m_pc[k] <= epc[k] & msk(k); m_p[k] <= 1'b0; m_v[k] <= 1'b1;
      end else if (!m_v[k] || stl[k]) begin
        m_v[k] <= 1'b1;
        if (rv[k]) begin m_p[k] <= 1'b1; m_t[k] <= rtgt[k] & msk(k); end
      end else if (rv[k]) begin
        m_pc[k] <= rtgt[k] & msk(k); m_p[k] <= 1'b0;
      end else if (m_p[k]) begin
        m_pc[k] <= m_t[k]; m_p[k] <= 1'b0;
      end else begin
        m_pc[k] <= (m_pc[k] + 32'd4) & msk(k);
      end
    end
  end

  // ---------------- literal expectations posted by the stimulus ----------------
  logic        lit_on  [2] = '{1'b0, 1'b0};
  logic [31:0] lit_pc  [2];
  logic        lit_v   [2];
  logic        lit_p   [2];
  logic        lit_ad  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: model every cycle, literals when posted
  initial begin
    logic [31:0] apc [2];
    logic [31:0] app [2];
    logic        av  [2];
    logic        ap  [2];
    logic        aad [2];
    forever begin
      @(negedge clk);
      apc[0] = pc_a;          app[0] = pcp_a;          av[0] = val_a; ap[0] = pend_a; aad[0] = adel_a;
      apc[1] = {24'd0, pc_b}; app[1] = {24'd0, pcp_b}; av[1] = val_b; ap[1] = pend_b; aad[1] = adel_b;
      for (int k = 0; k < 2; k++) begin
        if (m_en[k]) begin
          chk($sformatf("model_pc%0d", k), apc[k], m_pc[k]);
          chk($sformatf("model_pcplus%0d", k), app[k], (m_pc[k] + 32'd4) & msk(k));
          chk($sformatf("model_valid%0d", k), {31'd0, av[k]}, {31'd0, m_v[k]});
          chk($sformatf("model_pend%0d", k), {31'd0, ap[k]}, {31'd0, m_p[k]});
          chk($sformatf("model_adel%0d", k), {31'd0, aad[k]}, {31'd0, (m_pc[k][1:0] != 2'b00)});
        end
        if (lit_on[k]) begin
          chk($sformatf("lit_pc%0d", k), apc[k], lit_pc[k]);
          chk($sformatf("lit_valid%0d", k), {31'd0, av[k]}, {31'd0, lit_v[k]});
          chk($sformatf("lit_pend%0d", k), {31'd0, ap[k]}, {31'd0, lit_p[k]});
          chk($sformatf("lit_adel%0d", k), {31'd0, aad[k]}, {31'd0, lit_ad[k]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    lit_on[0] = 1'b0;
    lit_on[1] = 1'b0;
  endtask

  task automatic expect_st(input int k, input logic [31:0] p, input logic v,
                           input logic pe, input logic ad);
    lit_on[k] = 1'b1; lit_pc[k] = p; lit_v[k] = v; lit_p[k] = pe; lit_ad[k] = ad;
  endtask

  task automatic drive(input int k, input logic s, input logic r, input logic [31:0] t);
    stl[k] = s; rv[k] = r; rtgt[k] = t;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; stl[k] = 1'b0; rv[k] = 1'b0; exc[k] = 1'b0; eret[k] = 1'b0;
      rtgt[k] = 32'd0; epc[k] = 32'd0;
    end
    cyc();                                 expect_st(0, 32'h3000, 1'b0, 1'b0, 1'b0);
    rst[0] = 1'b0;
    cyc();                                 expect_st(0, 32'h3000, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(0, 32'h3004, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(0, 32'h3008, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(0, 32'h300C, 1'b1, 1'b0, 1'b0);
    // three-cycle stall with one redirect pulse
    drive(0, 1'b1, 1'b1, 32'h3100);
    cyc();                                 expect_st(0, 32'h300C, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h0);
    cyc();                                 expect_st(0, 32'h300C, 1'b1, 1'b1, 1'b0);
    cyc();                                 expect_st(0, 32'h300C, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0);
    cyc();                                 expect_st(0, 32'h3100, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(0, 32'h3104, 1'b1, 1'b0, 1'b0);
    // two buffered redirects, then a live one as the stall drops
    drive(0, 1'b1, 1'b1, 32'h3100);
    cyc();                                 expect_st(0, 32'h3104, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 32'h3200);
    cyc();                                 expect_st(0, 32'h3104, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h3300);
    cyc();                                 expect_st(0, 32'h3300, 1'b1, 1'b0, 1'b0);
    // exception beats stall, redirect, eret and a full buffer
    drive(0, 1'b1, 1'b1, 32'h3400);
    cyc();                                 expect_st(0, 32'h3300, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 32'h3500); exc[0] = 1'b1; eret[0] = 1'b1; epc[0] = 32'h3010;
    cyc();                                 expect_st(0, 32'h4180, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h0); exc[0] = 1'b0;
    cyc();                                 expect_st(0, 32'h3010, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0); eret[0] = 1'b0;
    cyc();                                 expect_st(0, 32'h3014, 1'b1, 1'b0, 1'b0);
    // reset while a redirect is buffered
    drive(0, 1'b1, 1'b1, 32'h3600);
    cyc();                                 expect_st(0, 32'h3014, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h0); rst[0] = 1'b1;
    cyc();                                 expect_st(0, 32'h3000, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0); rst[0] = 1'b0;
    cyc();                                 expect_st(0, 32'h3000, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(0, 32'h3004, 1'b1, 1'b0, 1'b0);
    // redirect during the boot bubble is buffered, then taken
    rst[0] = 1'b1;
    cyc();                                 expect_st(0, 32'h3000, 1'b0, 1'b0, 1'b0);
    rst[0] = 1'b0; drive(0, 1'b0, 1'b1, 32'h3700);
    cyc();                                 expect_st(0, 32'h3000, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0);
    cyc();                                 expect_st(0, 32'h3700, 1'b1, 1'b0, 1'b0);
    // 8-bit instance: wrap-around and misaligned fetch
    expect_st(1, 32'hF8, 1'b0, 1'b0, 1'b0);
    rst[1] = 1'b0;
    cyc();                                 expect_st(1, 32'hF8, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(1, 32'hFC, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(1, 32'h00, 1'b1, 1'b0, 1'b0);
    cyc();                                 expect_st(1, 32'h04, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b1, 32'h02);
    cyc();                                 expect_st(1, 32'h02, 1'b1, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 32'h0);
    cyc();                                 expect_st(1, 32'h06, 1'b1, 1'b0, 1'b1);
    exc[1] = 1'b1;
    cyc();                                 expect_st(1, 32'h80, 1'b1, 1'b0, 1'b0);
    exc[1] = 1'b0;
    cyc();                                 expect_st(1, 32'h84, 1'b1, 1'b0, 1'b0);
    // short free mix on both instances
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC);
        exc[k]  = ($urandom_range(0, 15) == 0);
        eret[k] = ($urandom_range(0, 15) == 0);
        epc[k]  = $urandom;
        rst[k]  = ($urandom_range(0, 31) == 0);
      end
      cyc();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit_gen2.md
Name: pc_unit_gen2

Overview:
Parametrised program-counter unit for the fetch stage of the MIPS pipeline. It is the successor to the plain stall/reset PC register. It adds:
- a configurable address width, reset vector and increment;
- in-unit sequential increment;
- a branch/jump redirect port;
- exception entry and ERET return that override stall;
- a one-entry pending-redirect buffer, so a redirect arriving during a stall is not lost.

Parameters:
ADDR_W, 32, width of all address ports and registers
RESET_VEC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, PC value loaded on exception entry
INC, 4, sequential increment added to pc

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; holds pc when high
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  ADDR_W  branch/jump destination
exc_req  in  1  exception/interrupt entry request
eret_req  in  1  return-from-exception request
epc_in  in  ADDR_W  return address from CP0 EPC
pc  out  ADDR_W  current fetch address (registered)
pc_plus  out  ADDR_W  pc + INC (combinational, modulo 2^ADDR_W)
pc_valid  out  1  pc is a real fetch address (registered)
pending  out  1  a buffered redirect is waiting (registered)
adel  out  1  pc[1:0] != 0, misaligned fetch flag (combinational)

Behaviour:
- Reset is synchronous, active-high, on clock clk. On reset: pc=RESET_VEC, pc_valid=0, pending=0, pending_target=0. Reset overrides every other input.
- State:
  - pc register
  - pc_valid flag (bubble state BOOT, then RUN)
  - pending flag plus pending_target register (buffer EMPTY/FULL)
- Per-edge priority when reset=0, highest first:
  1. exc_req=1: pc<=EXC_VEC, pending<=0, pc_valid<=1. Ignores stall, redirect and eret_req.
  2. eret_req=1: pc<=epc_in, pending<=0, pc_valid<=1. Ignores stall and redirect.
  3. pc_valid=0 (BOOT): pc holds, pc_valid<=1. Any redirect_valid in this cycle is captured into the buffer as in rule 4.
  4. stall=1: pc holds. If redirect_valid=1, then pending_target<=redirect_target and pending<=1. A newer redirect overwrites an older pending one; the buffer depth is 1, and the last writer wins.
  5. stall=0 and redirect_valid=1: pc<=redirect_target, pending<=0. A live redirect beats a buffered one.
  6. stall=0 and pending=1: pc<=pending_target, pending<=0.
  7. Otherwise: pc<=pc+INC, truncated to ADDR_W bits. Wrap-around from all-ones is allowed silently.
- Latency: every pc update is visible one cycle after the qualifying edge. There is no combinational path from any input to pc.
- pending_target holds its value when pending=0; verification must not check it in that state.
- adel is purely combinational from pc. The unit still advances a misaligned pc; trapping is CP0's job.
- Reset asserted mid-stall with pending=1: the buffer is discarded and pc=RESET_VEC.

Test Plan:
- Reset then free-run, no stall → pc=0x3000 with pc_valid=0; next cycle pc=0x3000 with pc_valid=1; then 0x3004, 0x3008.
- stall=1 for 3 cycles with redirect_valid pulsed once (target 0x3100) → pc holds 0x300C and pending=1. On the edge where stall drops, pc=0x3100 and pending=0.
- Two redirects during one stall (0x3100, then 0x3200), followed by a live redirect 0x3300 in the same cycle stall drops → pc=0x3300, pending=0.
- exc_req=1 with stall=1, redirect_valid=1 and eret_req=1 all asserted → pc=0x4180, pending=0. Then eret_req with epc_in=0x3010 → pc=0x3010.
- ADDR_W=8, RESET_VEC=8'hF8, INC=4 → pc sequence F8, F8 (boot), FC, 00, 04, with wrap-around. Redirect to 8'h02 → adel=1 and pc advances to 06.
- Reset asserted while pending=1 → pc=RESET_VEC and pending=0. The old target is never loaded.
